pic_init_sequencer: RTL and testbench

PIC_INIT_SEQUENCER -- requirements
Module: pic_init_sequencer

---
 rtl/pic_pkg.sv | 67 ++++++
 rtl/pic_init_sequencer_if.sv | 50 +++++
 rtl/pic_ocw_decoder.sv | 64 ++++++
 rtl/pic_init_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_pic_init_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC initialisation sequencer: state encoding,
// command-word bit positions and OCW2 command encodings.
package pic_pkg;

    // Initialisation FSM state encoding (also driven out on init_state)
    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } init_state_e;

    // ICW4 fields in their bus bit order (bit 0 = upm ... bit 4 = sfnm)
    typedef struct packed {
        logic sfnm;
        logic buffered_mode;
        logic master_slave;
        logic aeoi;
        logic upm;
    } icw4_t;

    // ICW1 bit positions
    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_LTIM_BIT = 3;

    // ICW2 vector base field
    localparam int ICW2_VEC_MSB = 7;
    localparam int ICW2_VEC_LSB = 3;

    // ICW4 bit positions
    localparam int ICW4_UPM_BIT  = 0;
    localparam int ICW4_AEOI_BIT = 1;
    localparam int ICW4_MS_BIT   = 2;
    localparam int ICW4_BUF_BIT  = 3;
    localparam int ICW4_SFNM_BIT = 4;

    // OCW2 fields: R/SL/EOI in the top three bits, level in the bottom three
    localparam int OCW2_CMD_MSB = 7;
    localparam int OCW2_CMD_LSB = 5;
    localparam int OCW2_LVL_MSB = 2;
    localparam int OCW2_LVL_LSB = 0;

    // OCW3 bit positions
    localparam int OCW3_ESMM_BIT = 6;
    localparam int OCW3_SMM_BIT  = 5;
    localparam int OCW3_P_BIT    = 2;
    localparam int OCW3_RR_BIT   = 1;
    localparam int OCW3_RIS_BIT  = 0;

    // OCW2 command encodings (R, SL, EOI)
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
    localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;

    // True for OCW2 commands that produce an eoi_valid pulse; the two
    // rotate-on-AEOI mode commands only change internal state.
    function automatic logic ocw2_is_pulse(input logic [2:0] cmd);
        return (cmd != OCW2_ROT_AEOI_SET) && (cmd != OCW2_ROT_AEOI_CLR);
    endfunction

endpackage

// File: rtl/pic_init_sequencer_if.sv
// Bus-side write strobes and data, plus the configuration state published
// by the sequencer.
interface pic_init_sequencer_if;
    import pic_pkg::*;

    logic [7:0] internal_data_bus;
    logic       ICW1;
    logic       ICW2_4;
    logic       OCW1;
    logic       OCW2;
    logic       OCW3;

    logic [2:0] init_state;
    logic       init_done;
    logic       ic4;
    logic       single_mode;
    logic       ltim;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       upm;
    logic       aeoi;
    logic       master_slave;
    logic       buffered_mode;
    logic       sfnm;
    logic [7:0] imr;
    logic       eoi_valid;
    logic [2:0] eoi_cmd;
    logic [2:0] eoi_level;
    logic       rotate_aeoi;
    logic       special_mask;
    logic       read_isr;
    logic       poll_valid;

    modport master (
        output internal_data_bus, ICW1, ICW2_4, OCW1, OCW2, OCW3,
        input  init_state, init_done, ic4, single_mode, ltim, vector_base,
               cascade_cfg, upm, aeoi, master_slave, buffered_mode, sfnm,
               imr, eoi_valid, eoi_cmd, eoi_level, rotate_aeoi,
               special_mask, read_isr, poll_valid
    );

    modport slave (
        input  internal_data_bus, ICW1, ICW2_4, OCW1, OCW2, OCW3,
        output init_state, init_done, ic4, single_mode, ltim, vector_base,
               cascade_cfg, upm, aeoi, master_slave, buffered_mode, sfnm,
               imr, eoi_valid, eoi_cmd, eoi_level, rotate_aeoi,
               special_mask, read_isr, poll_valid
    );

endinterface

// File: rtl/pic_ocw_decoder.sv
// Combinational OCW2/OCW3 decode. Produces update requests only; all state
// is held by the sequencer. Only the data bits that OCW2/OCW3 use are fed in:
// hi_i = bus[7:5], lo_i = bus[2:0].
module pic_ocw_decoder
    import pic_pkg::*;
(
    input  logic       ready_i,
    input  logic       ocw2_i,
    input  logic       ocw3_i,
    input  logic [2:0] hi_i,
    input  logic [2:0] lo_i,
    output logic       eoi_pulse_o,
    output logic [2:0] eoi_cmd_o,
    output logic [2:0] eoi_level_o,
    output logic       rot_set_o,
    output logic       rot_clr_o,
    output logic       smm_we_o,
    output logic       smm_val_o,
    output logic       ris_we_o,
    output logic       ris_val_o,
    output logic       poll_o
);

    localparam int HI_LSB = OCW2_CMD_LSB;

    // Decode OCW2 into an EOI pulse or a rotate-on-AEOI mode change
    always_comb begin
        eoi_pulse_o = 1'b0;
        rot_set_o   = 1'b0;
        rot_clr_o   = 1'b0;
        eoi_cmd_o   = hi_i;
        eoi_level_o = lo_i;
        if (ready_i && ocw2_i) begin
            if (hi_i == OCW2_ROT_AEOI_SET) begin
                rot_set_o = 1'b1;
            end else if (hi_i == OCW2_ROT_AEOI_CLR) begin
                rot_clr_o = 1'b1;
            end else begin
                eoi_pulse_o = ocw2_is_pulse(hi_i);
            end
        end else begin
            eoi_pulse_o = 1'b0;
        end
    end

    // Decode OCW3 into per-field write enables and a poll request
    always_comb begin
        smm_we_o  = 1'b0;
        smm_val_o = 1'b0;
        ris_we_o  = 1'b0;
        ris_val_o = 1'b0;
        poll_o    = 1'b0;
        if (ready_i && ocw3_i) begin
            smm_we_o  = hi_i[OCW3_ESMM_BIT - HI_LSB];
            smm_val_o = hi_i[OCW3_SMM_BIT - HI_LSB];
            ris_we_o  = lo_i[OCW3_RR_BIT];
            ris_val_o = lo_i[OCW3_RIS_BIT];
            poll_o    = lo_i[OCW3_P_BIT];
        end else begin
            poll_o = 1'b0;
        end
    end

endmodule

// File: rtl/pic_init_sequencer.sv
// PIC initialisation sequencer: walks ICW1..ICW4, then accepts OCW1..OCW3
// in READY. Every output is a flop; ICW1 restarts the sequence from any state.
module pic_init_sequencer
    import pic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    pic_init_sequencer_if.slave  bus
);

    init_state_e state_q, state_d;
    logic        ic4_q, ic4_d;
    logic        single_q, single_d;
    logic        ltim_q, ltim_d;
    logic [4:0]  vector_base_q, vector_base_d;
    logic [7:0]  cascade_q, cascade_d;
    icw4_t       icw4_q, icw4_d;
    logic [7:0]  imr_q, imr_d;
    logic        eoi_valid_q, eoi_valid_d;
    logic [2:0]  eoi_cmd_q, eoi_cmd_d;
    logic [2:0]  eoi_level_q, eoi_level_d;
    logic        rotate_q, rotate_d;
    logic        smm_q, smm_d;
    logic        ris_q, ris_d;
    logic        poll_q, poll_d;

    logic        ocw_en_s;
    logic        dec_eoi_pulse_s;
    logic [2:0]  dec_eoi_cmd_s;
    logic [2:0]  dec_eoi_level_s;
    logic        dec_rot_set_s;
    logic        dec_rot_clr_s;
    logic        dec_smm_we_s;
    logic        dec_smm_val_s;
    logic        dec_ris_we_s;
    logic        dec_ris_val_s;
    logic        dec_poll_s;

    // OCWs only act in READY, and a simultaneous ICW1 overrides them
    assign ocw_en_s = (state_q == ST_READY) && !bus.ICW1;

    pic_ocw_decoder u_ocw_decoder (
        .ready_i     (ocw_en_s),
        .ocw2_i      (bus.OCW2),
        .ocw3_i      (bus.OCW3),
        .hi_i        (bus.internal_data_bus[OCW2_CMD_MSB:OCW2_CMD_LSB]),
        .lo_i        (bus.internal_data_bus[OCW2_LVL_MSB:OCW2_LVL_LSB]),
        .eoi_pulse_o (dec_eoi_pulse_s),
        .eoi_cmd_o   (dec_eoi_cmd_s),
        .eoi_level_o (dec_eoi_level_s),
        .rot_set_o   (dec_rot_set_s),
        .rot_clr_o   (dec_rot_clr_s),
        .smm_we_o    (dec_smm_we_s),
        .smm_val_o   (dec_smm_val_s),
        .ris_we_o    (dec_ris_we_s),
        .ris_val_o   (dec_ris_val_s),
        .poll_o      (dec_poll_s)
    );

    // Next-state and next-register computation for the whole sequencer
    always_comb begin
        state_d       = state_q;
        ic4_d         = ic4_q;
        single_d      = single_q;
        ltim_d        = ltim_q;
        vector_base_d = vector_base_q;
        cascade_d     = cascade_q;
        icw4_d        = icw4_q;
        imr_d         = imr_q;
        eoi_valid_d   = 1'b0;
        eoi_cmd_d     = eoi_cmd_q;
        eoi_level_d   = eoi_level_q;
        rotate_d      = rotate_q;
        smm_d         = smm_q;
        ris_d         = ris_q;
        poll_d        = 1'b0;

        if (bus.ICW1) begin
            ic4_d    = bus.internal_data_bus[ICW1_IC4_BIT];
            single_d = bus.internal_data_bus[ICW1_SNGL_BIT];
            ltim_d   = bus.internal_data_bus[ICW1_LTIM_BIT];
            imr_d    = 8'h00;
            smm_d    = 1'b0;
            ris_d    = 1'b0;
            rotate_d = 1'b0;
            icw4_d   = '0;
            state_d  = ST_WAIT_ICW2;
        end else begin
            case (state_q)
                ST_WAIT_ICW2: begin
                    if (bus.ICW2_4) begin
                        vector_base_d = bus.internal_data_bus[ICW2_VEC_MSB:ICW2_VEC_LSB];
                        if (!single_q) begin
                            state_d = ST_WAIT_ICW3;
                        end else if (ic4_q) begin
                            state_d = ST_WAIT_ICW4;
                        end else begin
                            state_d = ST_READY;
                        end
                    end else begin
                        state_d = ST_WAIT_ICW2;
                    end
                end
                ST_WAIT_ICW3: begin
                    if (bus.ICW2_4) begin
                        cascade_d = bus.internal_data_bus;
                        state_d   = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                    end else begin
                        state_d = ST_WAIT_ICW3;
                    end
                end
                ST_WAIT_ICW4: begin
                    if (bus.ICW2_4) begin
                        icw4_d  = icw4_t'(bus.internal_data_bus[ICW4_SFNM_BIT:ICW4_UPM_BIT]);
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT_ICW4;
                    end
                end
                ST_READY: begin
                    if (bus.OCW1) begin
                        imr_d = bus.internal_data_bus;
                    end else begin
                        imr_d = imr_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase

            // Decoder requests are already gated to READY without ICW1
            if (dec_eoi_pulse_s) begin
                eoi_valid_d = 1'b1;
                eoi_cmd_d   = dec_eoi_cmd_s;
                eoi_level_d = dec_eoi_level_s;
            end else begin
                eoi_valid_d = 1'b0;
            end
            if (dec_rot_set_s) begin
                rotate_d = 1'b1;
            end else if (dec_rot_clr_s) begin
                rotate_d = 1'b0;
            end else begin
                rotate_d = rotate_q;
            end
            if (dec_smm_we_s) begin
                smm_d = dec_smm_val_s;
            end else begin
                smm_d = smm_q;
            end
            if (dec_ris_we_s) begin
                ris_d = dec_ris_val_s;
            end else begin
                ris_d = ris_q;
            end
            poll_d = dec_poll_s;
        end
    end

    // State and configuration registers; reset discards any partial setup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_UNINIT;
            ic4_q         <= 1'b0;
            single_q      <= 1'b0;
            ltim_q        <= 1'b0;
            vector_base_q <= 5'd0;
            cascade_q     <= 8'h00;
            icw4_q        <= '0;
            imr_q         <= 8'h00;
            eoi_valid_q   <= 1'b0;
            eoi_cmd_q     <= 3'd0;
            eoi_level_q   <= 3'd0;
            rotate_q      <= 1'b0;
            smm_q         <= 1'b0;
            ris_q         <= 1'b0;
            poll_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ic4_q         <= ic4_d;
            single_q      <= single_d;
            ltim_q        <= ltim_d;
            vector_base_q <= vector_base_d;
            cascade_q     <= cascade_d;
            icw4_q        <= icw4_d;
            imr_q         <= imr_d;
            eoi_valid_q   <= eoi_valid_d;
            eoi_cmd_q     <= eoi_cmd_d;
            eoi_level_q   <= eoi_level_d;
            rotate_q      <= rotate_d;
            smm_q         <= smm_d;
            ris_q         <= ris_d;
            poll_q        <= poll_d;
        end
    end

    assign bus.init_state    = state_q;
    assign bus.init_done     = (state_q == ST_READY);
    assign bus.ic4           = ic4_q;
    assign bus.single_mode   = single_q;
    assign bus.ltim          = ltim_q;
    assign bus.vector_base   = vector_base_q;
    assign bus.cascade_cfg   = cascade_q;
    assign bus.upm           = icw4_q.upm;
    assign bus.aeoi          = icw4_q.aeoi;
    assign bus.master_slave  = icw4_q.master_slave;
    assign bus.buffered_mode = icw4_q.buffered_mode;
    assign bus.sfnm          = icw4_q.sfnm;
    assign bus.imr           = imr_q;
    assign bus.eoi_valid     = eoi_valid_q;
    assign bus.eoi_cmd       = eoi_cmd_q;
    assign bus.eoi_level     = eoi_level_q;
    assign bus.rotate_aeoi   = rotate_q;
    assign bus.special_mask  = smm_q;
    assign bus.read_isr      = ris_q;
    assign bus.poll_valid    = poll_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed bench for pic_init_sequencer: expected output values are queued
// as each write is issued and compared on the following falling edge.
module tb_pic_init_sequencer;
    import pic_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pic_init_sequencer_if bus ();

    pic_init_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_ICW1 = 5'b00001;
    localparam logic [4:0] F_ICW2 = 5'b00010;
    localparam logic [4:0] F_OCW1 = 5'b00100;
    localparam logic [4:0] F_OCW2 = 5'b01000;
    localparam logic [4:0] F_OCW3 = 5'b10000;

    localparam int S_STATE = 0,  S_DONE = 1,  S_IC4 = 2,   S_SNGL = 3,  S_LTIM = 4;
    localparam int S_VB    = 5,  S_CASC = 6,  S_UPM = 7,   S_AEOI = 8,  S_MS   = 9;
    localparam int S_BUF   = 10, S_SFNM = 11, S_IMR = 12,  S_EOIV = 13, S_EOIC = 14;
    localparam int S_EOIL  = 15, S_ROT  = 16, S_SMM = 17,  S_RIS  = 18, S_POLL = 19;
    localparam int S_COUNT = 20;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } chk_t;

    chk_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_STATE: return {5'd0, bus.init_state};
            S_DONE:  return {7'd0, bus.init_done};
            S_IC4:   return {7'd0, bus.ic4};
            S_SNGL:  return {7'd0, bus.single_mode};
            S_LTIM:  return {7'd0, bus.ltim};
            S_VB:    return {3'd0, bus.vector_base};
            S_CASC:  return bus.cascade_cfg;
            S_UPM:   return {7'd0, bus.upm};
            S_AEOI:  return {7'd0, bus.aeoi};
            S_MS:    return {7'd0, bus.master_slave};
            S_BUF:   return {7'd0, bus.buffered_mode};
            S_SFNM:  return {7'd0, bus.sfnm};
            S_IMR:   return bus.imr;
            S_EOIV:  return {7'd0, bus.eoi_valid};
            S_EOIC:  return {5'd0, bus.eoi_cmd};
            S_EOIL:  return {5'd0, bus.eoi_level};
            S_ROT:   return {7'd0, bus.rotate_aeoi};
            S_SMM:   return {7'd0, bus.special_mask};
            S_RIS:   return {7'd0, bus.read_isr};
            S_POLL:  return {7'd0, bus.poll_valid};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
        chk_t c;
        c.tag = tag;
        c.sel = sel;
        c.val = v;
        sb.push_back(c);
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < S_COUNT; i++) begin
            expect_val($sformatf("%s_%0d", tag, i), i, 8'h00);
        end
    endtask

    task automatic check_sb();
        chk_t       c;
        logic [7:0] o;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            o = obs(c.sel);
            n_assert++;
            assert (o === c.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", c.tag, o, c.val);
            end
        end
    endtask

    // Called on a falling edge: hold flags for one rising edge, return on the next falling edge
    task automatic drive(input logic [4:0] fl, input logic [7:0] d);
        {bus.OCW3, bus.OCW2, bus.OCW1, bus.ICW2_4, bus.ICW1} = fl;
        bus.internal_data_bus = d;
        @(posedge clk);
        @(negedge clk);
        {bus.OCW3, bus.OCW2, bus.OCW1, bus.ICW2_4, bus.ICW1} = F_NONE;
    endtask

    initial begin
        rst_n = 1'b0;
        {bus.OCW3, bus.OCW2, bus.OCW1, bus.ICW2_4, bus.ICW1} = F_NONE;
        bus.internal_data_bus = 8'h00;
        #2;
        expect_all_zero("reset");
        check_sb();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // OCW1 in UNINIT is ignored
        expect_val("uninit_ocw1_imr", S_IMR, 8'h00);
        expect_val("uninit_ocw1_state", S_STATE, 8'd0);
        drive(F_OCW1, 8'hFF);
        check_sb();

        // Single mode with ICW4
        expect_val("icw1_state", S_STATE, 8'd1);
        expect_val("icw1_ic4", S_IC4, 8'd1);
        expect_val("icw1_sngl", S_SNGL, 8'd1);
        expect_val("icw1_ltim", S_LTIM, 8'd0);
        drive(F_ICW1, 8'h13);
        check_sb();

        // OCW1 before READY does not touch imr
        expect_val("w2_ocw1_imr", S_IMR, 8'h00);
        expect_val("w2_ocw1_state", S_STATE, 8'd1);
        drive(F_OCW1, 8'h55);
        check_sb();

        expect_val("icw2_vb", S_VB, 8'h08);
        expect_val("icw2_state", S_STATE, 8'd3);
        expect_val("icw2_done", S_DONE, 8'd0);
        drive(F_ICW2, 8'h40);
        check_sb();

        // OCW2 before READY produces no pulse
        expect_val("w4_ocw2_eoiv", S_EOIV, 8'd0);
        expect_val("w4_ocw2_state", S_STATE, 8'd3);
        drive(F_OCW2, 8'h63);
        check_sb();

        expect_val("icw4_state", S_STATE, 8'd4);
        expect_val("icw4_done", S_DONE, 8'd1);
        expect_val("icw4_upm", S_UPM, 8'd1);
        expect_val("icw4_aeoi", S_AEOI, 8'd1);
        expect_val("icw4_ms", S_MS, 8'd0);
        expect_val("icw4_buf", S_BUF, 8'd0);
        expect_val("icw4_sfnm", S_SFNM, 8'd0);
        drive(F_ICW2, 8'h03);
        check_sb();

        expect_val("ocw1_imr", S_IMR, 8'hA5);
        drive(F_OCW1, 8'hA5);
        check_sb();

        // Specific EOI: one-cycle pulse with command and level
        expect_val("ocw2_eoiv", S_EOIV, 8'd1);
        expect_val("ocw2_cmd", S_EOIC, 8'd3);
        expect_val("ocw2_lvl", S_EOIL, 8'd3);
        expect_val("ocw2_rot", S_ROT, 8'd0);
        drive(F_OCW2, 8'h63);
        check_sb();
        expect_val("ocw2_eoiv_drop", S_EOIV, 8'd0);
        drive(F_NONE, 8'h00);
        check_sb();

        expect_val("rotset_rot", S_ROT, 8'd1);
        expect_val("rotset_eoiv", S_EOIV, 8'd0);
        drive(F_OCW2, 8'h80);
        check_sb();

        expect_val("ocw3a_smm", S_SMM, 8'd1);
        expect_val("ocw3a_ris", S_RIS, 8'd1);
        expect_val("ocw3a_poll", S_POLL, 8'd0);
        drive(F_OCW3, 8'h6B);
        check_sb();

        expect_val("ocw3b_poll", S_POLL, 8'd1);
        expect_val("ocw3b_smm", S_SMM, 8'd1);
        expect_val("ocw3b_ris", S_RIS, 8'd1);
        drive(F_OCW3, 8'h0C);
        check_sb();
        expect_val("ocw3b_poll_drop", S_POLL, 8'd0);
        drive(F_NONE, 8'h00);
        check_sb();

        expect_val("rotclr_rot", S_ROT, 8'd0);
        expect_val("rotclr_eoiv", S_EOIV, 8'd0);
        drive(F_OCW2, 8'h00);
        check_sb();
        expect_val("rotset2_rot", S_ROT, 8'd1);
        drive(F_OCW2, 8'h80);
        check_sb();

        // ICW1 together with OCW1/OCW2/OCW3: ICW1 wins and clears state
        expect_val("prio_state", S_STATE, 8'd1);
        expect_val("prio_done", S_DONE, 8'd0);
        expect_val("prio_imr", S_IMR, 8'h00);
        expect_val("prio_rot", S_ROT, 8'd0);
        expect_val("prio_smm", S_SMM, 8'd0);
        expect_val("prio_ris", S_RIS, 8'd0);
        expect_val("prio_upm", S_UPM, 8'd0);
        expect_val("prio_aeoi", S_AEOI, 8'd0);
        expect_val("prio_ic4", S_IC4, 8'd0);
        expect_val("prio_sngl", S_SNGL, 8'd0);
        expect_val("prio_eoiv", S_EOIV, 8'd0);
        expect_val("prio_poll", S_POLL, 8'd0);
        drive(F_ICW1 | F_OCW1 | F_OCW2 | F_OCW3, 8'h10);
        check_sb();

        // Cascade mode without ICW4
        expect_val("casc_icw2_vb", S_VB, 8'h01);
        expect_val("casc_icw2_state", S_STATE, 8'd2);
        drive(F_ICW2, 8'h08);
        check_sb();
        expect_val("casc_icw3_cfg", S_CASC, 8'h04);
        expect_val("casc_icw3_state", S_STATE, 8'd4);
        expect_val("casc_icw3_upm", S_UPM, 8'd0);
        expect_val("casc_icw3_aeoi", S_AEOI, 8'd0);
        expect_val("casc_icw3_sfnm", S_SFNM, 8'd0);
        drive(F_ICW2, 8'h04);
        check_sb();

        // Restart, stop in WAIT_ICW3, check OCW3 is ignored there
        drive(F_ICW1, 8'h10);
        expect_val("w3_state", S_STATE, 8'd2);
        drive(F_ICW2, 8'h08);
        check_sb();
        expect_val("w3_ocw3_smm", S_SMM, 8'd0);
        expect_val("w3_ocw3_ris", S_RIS, 8'd0);
        drive(F_OCW3, 8'h6B);
        check_sb();

        // Asynchronous reset mid-sequence, checked before any rising edge
        #1;
        rst_n = 1'b0;
        #1;
        expect_all_zero("midrst");
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;

        expect_val("postrst_state", S_STATE, 8'd0);
        expect_val("postrst_vb", S_VB, 8'h00);
        expect_val("postrst_casc", S_CASC, 8'h00);
        drive(F_ICW2, 8'h08);
        check_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
